pipe_stage_reg: RTL and testbench

- Generic parametrised pipeline-stage register that succeeds the fixed-field EX/MEM register; one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a separately-gated control field over a valid/ready handshake.
- Optional 2-entry skid buffer makes in_ready a pure register output.
- Adds synchronous flush (bubble insertion), occupancy reporting and a saturating stall counter.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: payload + masked control over valid/ready,
// optional two-entry skid buffer, synchronous flush, occupancy and stall count.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              load_main, load_skid, pop_skid;
    logic              in_ready_q, in_xfer, out_xfer;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Without a skid buffer, in_ready already blocks the BUSY in-only case,
    // so FULL is unreachable and the same FSM serves both modes.
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: if (in_xfer) begin
                load_main = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (out_xfer) begin
                pop_skid  = 1'b1;
                state_nxt = BUSY;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            pop_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (pop_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Bubbles must never present live write enables downstream.
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign occupancy = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance, no-skid instance and a
// narrow-counter instance for saturation.
module tb_pipe_stage_reg;

    localparam int DW = 69;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          m_in_ready, m_out_valid;
    logic [DW-1:0] m_out_data;
    logic [CW-1:0] m_out_ctrl;
    logic [1:0]    m_occ;
    logic [15:0]   m_stall;

    logic          t_in_ready, t_out_valid;
    logic [DW-1:0] t_out_data;
    logic [CW-1:0] t_out_ctrl;
    logic [1:0]    t_occ;
    logic [1:0]    t_stall;

    logic          z_in_valid, z_out_ready, z_in_ready, z_out_valid;
    logic [7:0]    z_in_data, z_out_data;
    logic [CW-1:0] z_in_ctrl, z_out_ctrl;
    logic [1:0]    z_occ;
    logic [15:0]   z_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_main (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
        .out_ctrl(m_out_ctrl), .occupancy(m_occ), .stall_cnt(m_stall)
    );

    pipe_stage_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_ctrl(t_out_ctrl), .occupancy(t_occ), .stall_cnt(t_stall)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_ctrl(z_in_ctrl),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .out_ctrl(z_out_ctrl), .occupancy(z_occ), .stall_cnt(z_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_data = '0; z_in_ctrl = '0;
        #12;
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", m_in_ready); end
        checks++; if (m_out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", m_out_data); end
        checks++; if (m_out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %0h expected 0", m_out_ctrl); end
        checks++; if (m_occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", m_occ); end
        checks++; if (m_stall !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", m_stall); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i);
            in_ctrl = CW'(i + 8);
            step();
            checks++; if (m_out_valid !== 1'b1 || m_out_data !== DW'(i)) begin errors++; $display("FAIL stream_data%0d: got v=%0b d=%0h expected v=1 d=%0h", i, m_out_valid, m_out_data, i); end
            checks++; if (m_out_ctrl !== CW'(i + 8) || m_occ !== 2'd1) begin errors++; $display("FAIL stream_ctrl_occ%0d: got c=%0h o=%0d expected c=%0h o=1", i, m_out_ctrl, m_occ, i + 8); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (m_occ !== 2'd0 || m_out_ctrl !== '0) begin errors++; $display("FAIL stream_drain: got o=%0d c=%0h expected o=0 c=0", m_occ, m_out_ctrl); end
        checks++; if (m_stall !== 16'd0) begin errors++; $display("FAIL stream_stall: got %0d expected 0", m_stall); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = DW'('hA); in_ctrl = 5'd1;
        step();
        checks++; if (m_occ !== 2'd1 || m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got o=%0d r=%0b expected o=1 r=1", m_occ, m_in_ready); end
        in_data = DW'('hB); in_ctrl = 5'd2;
        step();
        checks++; if (m_occ !== 2'd2 || m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got o=%0d r=%0b expected o=2 r=0", m_occ, m_in_ready); end
        checks++; if (m_out_data !== DW'('hA) || m_out_ctrl !== 5'd1) begin errors++; $display("FAIL bp_head: got d=%0h c=%0h expected d=a c=1", m_out_data, m_out_ctrl); end
        in_valid = 1'b0;
        step();
        checks++; if (m_occ !== 2'd2 || m_out_data !== DW'('hA)) begin errors++; $display("FAIL bp_hold: got o=%0d d=%0h expected o=2 d=a", m_occ, m_out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_reg: got %0b expected 0", m_in_ready); end
        step();
        checks++; if (m_out_data !== DW'('hB) || m_out_ctrl !== 5'd2 || m_occ !== 2'd1) begin errors++; $display("FAIL bp_second: got d=%0h c=%0h o=%0d expected d=b c=2 o=1", m_out_data, m_out_ctrl, m_occ); end
        step();
        checks++; if (m_out_valid !== 1'b0 || m_occ !== 2'd0) begin errors++; $display("FAIL bp_empty: got v=%0b o=%0d expected v=0 o=0", m_out_valid, m_occ); end
        checks++; if (m_stall !== 16'd2) begin errors++; $display("FAIL bp_stall: got %0d expected 2", m_stall); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(5); in_ctrl = 5'd5;
        step();
        in_data = DW'(6); in_ctrl = 5'd6; out_ready = 1'b1;
        step();
        checks++; if (m_out_data !== DW'(6) || m_occ !== 2'd1 || m_out_ctrl !== 5'd6) begin errors++; $display("FAIL simul: got d=%0h o=%0d c=%0h expected d=6 o=1 c=6", m_out_data, m_occ, m_out_ctrl); end
        in_valid = 1'b0;
        step();
        checks++; if (m_occ !== 2'd0 || m_stall !== 16'd2) begin errors++; $display("FAIL simul_drain: got o=%0d s=%0d expected o=0 s=2", m_occ, m_stall); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'('h11); in_ctrl = 5'd1;
        step();
        in_data = DW'('h22); in_ctrl = 5'd2;
        step();
        checks++; if (m_occ !== 2'd2) begin errors++; $display("FAIL flush_prefill: got o=%0d expected 2", m_occ); end
        in_data = DW'('h77); in_ctrl = 5'b11111; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b0 || m_out_ctrl !== '0) begin errors++; $display("FAIL flush_out: got v=%0b c=%0h expected v=0 c=0", m_out_valid, m_out_ctrl); end
        checks++; if (m_occ !== 2'd0 || m_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got o=%0d r=%0b expected o=0 r=1", m_occ, m_in_ready); end
        step();
        step();
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got v=%0b expected 0", m_out_valid); end
        in_valid = 1'b1; out_ready = 1'b1; in_data = DW'('h33); in_ctrl = 5'd3;
        step();
        checks++; if (m_out_data !== DW'('h33) || m_out_ctrl !== 5'd3) begin errors++; $display("FAIL flush_resume: got d=%0h c=%0h expected d=33 c=3", m_out_data, m_out_ctrl); end
        in_valid = 1'b0;
        step();
        checks++; if (m_occ !== 2'd0 || m_stall !== 16'd4) begin errors++; $display("FAIL flush_stall: got o=%0d s=%0d expected o=0 s=4", m_occ, m_stall); end
    endtask

    task automatic test_skid0();
        z_in_valid = 1'b1; z_in_data = 8'h5A; z_in_ctrl = 5'd7; z_out_ready = 1'b0;
        #1;
        checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_ready: got %0b expected 1", z_in_ready); end
        step();
        checks++; if (z_out_valid !== 1'b1 || z_out_data !== 8'h5A || z_occ !== 2'd1) begin errors++; $display("FAIL s0_load: got v=%0b d=%0h o=%0d expected v=1 d=5a o=1", z_out_valid, z_out_data, z_occ); end
        z_in_data = 8'h5B; z_in_ctrl = 5'd9;
        #1;
        checks++; if (z_in_ready !== 1'b0) begin errors++; $display("FAIL s0_blocked: got %0b expected 0", z_in_ready); end
        step();
        checks++; if (z_out_data !== 8'h5A || z_occ !== 2'd1) begin errors++; $display("FAIL s0_hold: got d=%0h o=%0d expected d=5a o=1", z_out_data, z_occ); end
        z_out_ready = 1'b1;
        #1;
        checks++; if (z_in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_ready: got %0b expected 1", z_in_ready); end
        step();
        checks++; if (z_out_data !== 8'h5B || z_out_ctrl !== 5'd9 || z_occ !== 2'd1) begin errors++; $display("FAIL s0_pass: got d=%0h c=%0h o=%0d expected d=5b c=9 o=1", z_out_data, z_out_ctrl, z_occ); end
        z_in_valid = 1'b0;
        step();
        checks++; if (z_out_valid !== 1'b0 || z_occ !== 2'd0 || z_out_ctrl !== '0) begin errors++; $display("FAIL s0_drain: got v=%0b o=%0d c=%0h expected 0 0 0", z_out_valid, z_occ, z_out_ctrl); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'('h44); in_ctrl = 5'd4;
        step();
        in_data = DW'('h55); in_ctrl = 5'd5;
        step();
        in_valid = 1'b0;
        checks++; if (m_occ !== 2'd2 || m_stall !== 16'd5) begin errors++; $display("FAIL ar_prefill: got o=%0d s=%0d expected o=2 s=5", m_occ, m_stall); end
        #3 rst = 1'b1;
        #1;
        checks++; if (m_out_valid !== 1'b0 || m_out_data !== '0 || m_out_ctrl !== '0) begin errors++; $display("FAIL ar_outputs: got v=%0b d=%0h c=%0h expected 0 0 0", m_out_valid, m_out_data, m_out_ctrl); end
        checks++; if (m_occ !== 2'd0 || m_in_ready !== 1'b1 || m_stall !== 16'd0) begin errors++; $display("FAIL ar_state: got o=%0d r=%0b s=%0d expected 0 1 0", m_occ, m_in_ready, m_stall); end
        #2 rst = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'('h66); in_ctrl = 5'd6;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        checks++; if (t_stall !== 2'd3 || t_occ !== 2'd1) begin errors++; $display("FAIL sat_narrow: got s=%0d o=%0d expected s=3 o=1", t_stall, t_occ); end
        checks++; if (m_stall !== 16'd5 || m_out_data !== DW'('h66)) begin errors++; $display("FAIL sat_wide: got s=%0d d=%0h expected s=5 d=66", m_stall, m_out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (t_occ !== 2'd0 || t_stall !== 2'd3) begin errors++; $display("FAIL sat_hold: got o=%0d s=%0d expected o=0 s=3", t_occ, t_stall); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_skid0();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
